// File: rtl/switch_debounce.sv
// -----------------------------------------------------------------------------
// switch_debounce
//
// Purpose:
//   Conditions the raw slide-switch bank before it reaches the adder's
//   SWITCH bus. Each bit passes through a two-flop synchronizer and then a
//   per-bit stability counter. A new synchronized level must differ from the
//   current output for CNT_MAX consecutive clock edges before the output
//   takes it. Any return to the old level before that clears the counter.
//   A one-cycle 'changed' strobe accompanies every output update.
//
//   Latency from a clean, held change on sw_in to sw_out is CNT_MAX+2 edges,
//   counted from the first edge that samples the new level into sync1.
//
// Build option:
//   SWITCH_DEBOUNCE_BYPASS_EN - when defined, the counters are removed and
//   sw_out follows the synchronizer output every edge (3-edge latency).
//   The port list is the same in both builds.
//
// Parameters:
//   WIDTH   - number of switch bits (>= 1)
//   CNT_MAX - consecutive edges a new level must persist (>= 1)
//   CNT_W   - counter width, derived from CNT_MAX
//
// Ports:
//   clk     in   1      system clock, rising edge
//   rst_n   in   1      asynchronous active-low reset
//   sw_in   in   WIDTH  raw switch levels, asynchronous to clk
//   sw_out  out  WIDTH  debounced, registered switch vector
//   changed out  1      one-cycle pulse, coincident with a new sw_out value
// -----------------------------------------------------------------------------
module switch_debounce #(
  parameter int WIDTH   = 8,
  parameter int CNT_MAX = 1000000,
  localparam int CNT_W  = $clog2(CNT_MAX + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] sw_in,
  output logic [WIDTH-1:0] sw_out,
  output logic             changed
);

  // Two-flop synchronizer. sync2_q is the only copy of sw_in used below.
  logic [WIDTH-1:0] sync1_q;
  logic [WIDTH-1:0] sync2_q;

  logic [WIDTH-1:0] sw_out_q;
  logic [WIDTH-1:0] sw_out_d;
  logic             changed_q;
  logic             changed_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= sw_in;
      sync2_q <= sync1_q;
    end
  end

`ifdef SWITCH_DEBOUNCE_BYPASS_EN

  // No filtering: the output is simply one more register stage.
  always_comb begin
    sw_out_d = sync2_q;
  end

`else

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CNT_MAX - 1);

  // Per-bit count of consecutive edges at which sync2 has disagreed with
  // the current output. Reaching CNT_LAST on a disagreeing edge accepts
  // the new level; the counter never advances past CNT_LAST.
  logic [WIDTH-1:0][CNT_W-1:0] cnt_q;
  logic [WIDTH-1:0][CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d    = cnt_q;
    sw_out_d = sw_out_q;
    for (int i = 0; i < WIDTH; i++) begin
      if (sync2_q[i] == sw_out_q[i]) begin
        // Agreement (or a bounce back) discards all progress.
        cnt_d[i] = '0;
      end else if (cnt_q[i] >= CNT_LAST) begin
        sw_out_d[i] = sync2_q[i];
        cnt_d[i]    = '0;
      end else begin
        cnt_d[i] = cnt_q[i] + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

`endif

  // Any bit updating this edge raises a single strobe for the next cycle,
  // so the strobe lines up with the new sw_out value.
  always_comb begin
    changed_d = |(sw_out_d ^ sw_out_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sw_out_q  <= '0;
      changed_q <= 1'b0;
    end else begin
      sw_out_q  <= sw_out_d;
      changed_q <= changed_d;
    end
  end

  assign sw_out  = sw_out_q;
  assign changed = changed_q;

endmodule

// File: tb/tb_switch_debounce.sv
// -----------------------------------------------------------------------------
// tb_switch_debounce
//
// Bench for switch_debounce with WIDTH=8, CNT_MAX=4. A reference model keeps
// the full history of sw_in values sampled at each edge since reset and, at
// every edge, decides each output bit by looking back over that history:
// a bit flips when the level seen by the filter (the sample from two edges
// earlier) has disagreed with the expected output for CNT_MAX consecutive
// edges. Directed steps cover reset, a clean change, bounce, independent
// bits, asynchronous reset and reset mid-count, followed by random stimulus.
// -----------------------------------------------------------------------------
module tb_switch_debounce;

  localparam int WIDTH   = 8;
  localparam int CNT_MAX = 4;
`ifdef SWITCH_DEBOUNCE_BYPASS_EN
  localparam bit BYPASS  = 1'b1;
`else
  localparam bit BYPASS  = 1'b0;
`endif
  localparam int LAT = BYPASS ? 3 : CNT_MAX + 2;

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic             clk   = 1'b0;
  logic             rst_n = 1'b0;
  logic [WIDTH-1:0] sw_in = '0;
  logic [WIDTH-1:0] sw_out;
  logic             changed;

  always #5 clk = ~clk;

  switch_debounce #(
    .WIDTH  (WIDTH),
    .CNT_MAX(CNT_MAX)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .sw_in  (sw_in),
    .sw_out (sw_out),
    .changed(changed)
  );

  // ---------------------------------------------------------------------------
  // Reference model
  // ---------------------------------------------------------------------------
  logic [WIDTH-1:0] samp_q[$];   // sw_in sampled at each edge since reset
  int               n_edges;
  logic [WIDTH-1:0] exp_out;
  logic             exp_chg;

  int checks = 0;
  int errors = 0;

  // Level the filter sees at edge m: the sample taken two edges earlier,
  // or zero while the synchronizer still holds its reset value.
  function automatic logic [WIDTH-1:0] seen_at(input int m);
    if (m >= 2) return samp_q[m-2];
    return '0;
  endfunction

  task automatic model_reset();
    samp_q.delete();
    n_edges = 0;
    exp_out = '0;
    exp_chg = 1'b0;
  endtask

  task automatic model_edge();
    logic [WIDTH-1:0] nxt;
    logic [WIDTH-1:0] u;
    int               run;
    samp_q.push_back(sw_in);
    nxt = exp_out;
    if (BYPASS) begin
      nxt = seen_at(n_edges);
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        run = 0;
        for (int m = n_edges; m >= 0 && run < CNT_MAX; m--) begin
          u = seen_at(m);
          if (u[i] != exp_out[i]) run++;
          else break;
        end
        if (run >= CNT_MAX) nxt[i] = ~exp_out[i];
      end
    end
    exp_chg = (nxt != exp_out);
    exp_out = nxt;
    n_edges++;
  endtask

  // ---------------------------------------------------------------------------
  // Checking
  // ---------------------------------------------------------------------------
  task automatic check(input string tag, input logic [WIDTH-1:0] obs,
                       input logic [WIDTH-1:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  // One rising edge: update the model, then compare just after the edge.
  // Inputs are only ever changed after this returns, away from the edge.
  task automatic tick();
    @(posedge clk);
    if (!rst_n) model_reset();
    else        model_edge();
    #1;
    check("sw_out_model", sw_out, exp_out);
    check("changed_model", {7'b0, changed}, {7'b0, exp_chg});
  endtask

  task automatic ticks(input int k);
    for (int j = 0; j < k; j++) tick();
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    logic [4:0] led_sum;
    int         pulses;
    model_reset();

    // Reset held with switches high: outputs stay cleared.
    rst_n = 1'b0;
    sw_in = 8'hFF;
    for (int k = 0; k < 5; k++) begin
      tick();
      check("reset_sw_out", sw_out, 8'h00);
      check("reset_changed", {7'b0, changed}, 8'h00);
    end
    rst_n = 1'b1;
    sw_in = 8'h00;
    ticks(3);

    // Clean change 00 -> 35.
    sw_in = 8'h35;
    for (int k = 1; k <= LAT; k++) begin
      tick();
      if (k < LAT) begin
        check("clean_hold", sw_out, 8'h00);
      end else begin
        check("clean_accept", sw_out, 8'h35);
        check("clean_pulse", {7'b0, changed}, 8'h01);
      end
    end
    tick();
    check("clean_pulse_end", {7'b0, changed}, 8'h00);

    // Bring everything back low.
    sw_in = 8'h00;
    ticks(LAT + 2);
    check("settle_low", sw_out, 8'h00);

    // Bounce on bit0: high 3, low 1, then high steady.
    pulses = 0;
    sw_in = 8'h01; ticks(3);
    sw_in = 8'h00; tick();
    sw_in = 8'h01;
    for (int k = 1; k <= LAT + 2; k++) begin
      tick();
      if (changed) pulses++;
      if (k == LAT - 1 && !BYPASS) check("bounce_early", sw_out, 8'h00);
      if (k == LAT) check("bounce_accept", sw_out, 8'h01);
    end
    if (!BYPASS) check("bounce_pulses", 8'(pulses), 8'd1);
    sw_in = 8'h00;
    ticks(LAT + 2);

    // Independent bits: bit7 at edge 1, bit1 at edge 3.
    pulses = 0;
    sw_in = 8'h80;
    for (int k = 1; k <= LAT + 3; k++) begin
      tick();
      if (changed) pulses++;
      if (k == 2) sw_in = 8'h82;
      if (k == LAT)     check("indep_bit7", sw_out, 8'h80);
      if (k == LAT + 2) check("indep_bit1", sw_out, 8'h82);
    end
    check("indep_pulses", 8'(pulses), 8'd2);
    led_sum = {1'b0, sw_out[7:4]} + {1'b0, sw_out[3:0]};
    check("adder_sum", {3'b0, led_sum}, 8'd10);

    // Drive all high, then reset asynchronously in mid-cycle.
    sw_in = 8'hFF;
    ticks(LAT + 2);
    check("all_high", sw_out, 8'hFF);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_sw_out", sw_out, 8'h00);
    check("async_changed", {7'b0, changed}, 8'h00);
    model_reset();
    tick();
    rst_n = 1'b1;

    // Reset mid-count: 4 edges of progress, 1 reset cycle, full restart.
    sw_in = 8'h01;
    ticks(4);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    for (int k = 1; k <= LAT; k++) begin
      tick();
      if (k < LAT) check("midreset_hold", sw_out, 8'h00);
      else         check("midreset_accept", sw_out, 8'h01);
    end

    // Random stimulus: sparse flips give both bounces and steady runs.
    for (int k = 0; k < 600; k++) begin
      if ($urandom_range(0, 3) == 0)
        sw_in = sw_in ^ (8'($urandom) & 8'($urandom) & 8'($urandom));
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
